// File: rtl/irq_loopback_pkg.sv
// Shared types and helpers for the IRQ loopback stimulus generator.
package irq_loopback_pkg;

    localparam int IRQ_W       = 32;
    localparam int TXN_FIELD_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP,
        DONE
    } irq_gen_state_e;

    // Transaction numbers are 1-based on the wire so a live word is never zero.
    function automatic logic [IRQ_W-1:0] make_irq_word(input logic [7:0]             cpu_idx,
                                                       input logic [TXN_FIELD_W-1:0] txn);
        return {cpu_idx, txn + TXN_FIELD_W'(1)};
    endfunction

endpackage

// File: rtl/irq_generator_if.sv
// Bundle between the IRQ generator and the loopback: words out, echoes back, status flags.
interface irq_generator_if
    import irq_loopback_pkg::*;
#(
    parameter int CPU_NB = 4
);

    logic [CPU_NB-1:0][IRQ_W-1:0] o_irq;
    logic [CPU_NB-1:0][IRQ_W-1:0] i_irq;
    logic [CPU_NB-1:0]            o_finish;
    logic [CPU_NB-1:0]            o_error;

    modport master (
        output o_irq,
        output o_finish,
        output o_error,
        input  i_irq
    );

    modport slave (
        input  o_irq,
        input  o_finish,
        input  o_error,
        output i_irq
    );

endinterface

// File: rtl/irq_gen_channel.sv
// One IRQ stimulus channel: issue a word, wait for its echo, pause, repeat until done or timeout.
module irq_gen_channel
    import irq_loopback_pkg::*;
#(
    parameter int CPU_IDX        = 0,
    parameter int TRANSACTION_NB = 1000,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IRQ_W-1:0] i_irq,
    output logic [IRQ_W-1:0] o_irq,
    output logic             o_finish,
    output logic             o_error
);

    localparam int TXN_W = $clog2(TRANSACTION_NB + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TXN_W-1:0] TXN_LAST = TXN_W'(TRANSACTION_NB - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    irq_gen_state_e   state_q, state_d;
    logic [IRQ_W-1:0] irq_q,   irq_d;
    logic [TXN_W-1:0] txn_q,   txn_d;
    logic [TMR_W-1:0] tmr_q,   tmr_d;
    logic [GAP_W-1:0] gap_q,   gap_d;
    logic             fin_q,   fin_d;
    logic             err_q,   err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            irq_q   <= '0;
            txn_q   <= '0;
            tmr_q   <= '0;
            gap_q   <= '0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            txn_q   <= txn_d;
            tmr_q   <= tmr_d;
            gap_q   <= gap_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        txn_d   = txn_q;
        tmr_d   = tmr_q;
        gap_d   = gap_q;
        fin_d   = fin_q;
        err_d   = err_q;
        case (state_q)
            IDLE: state_d = ISSUE;
            ISSUE: begin
                irq_d   = make_irq_word(8'(CPU_IDX), TXN_FIELD_W'(txn_q));
                tmr_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmr_d = tmr_q + 1'b1;
                // A matching echo beats the timeout when both land in the same cycle.
                if (i_irq == irq_q) begin
                    txn_d = txn_q + 1'b1;
                    if (txn_q == TXN_LAST) begin
                        state_d = DONE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = ISSUE;
                    end else begin
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ISSUE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            DONE:    fin_d   = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign o_irq    = irq_q;
    assign o_finish = fin_q;
    assign o_error  = err_q;

endmodule

// File: rtl/irq_generator.sv
// IRQ loopback stimulus generator: CPU_NB independent channels, wiring only.
module irq_generator
    import irq_loopback_pkg::*;
#(
    parameter int CPU_NB         = 4,
    parameter int TRANSACTION_NB = 1000,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    irq_generator_if.master    bus
);

    logic [CPU_NB-1:0][IRQ_W-1:0] irq;
    logic [CPU_NB-1:0]            finish;
    logic [CPU_NB-1:0]            error;

    for (genvar g = 0; g < CPU_NB; g++) begin : g_ch
        irq_gen_channel #(
            .CPU_IDX       (g),
            .TRANSACTION_NB(TRANSACTION_NB),
            .GAP_CYCLES    (GAP_CYCLES),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_irq   (bus.i_irq[g]),
            .o_irq   (irq[g]),
            .o_finish(finish[g]),
            .o_error (error[g])
        );
    end

    assign bus.o_irq    = irq;
    assign bus.o_finish = finish;
    assign bus.o_error  = error;

endmodule

// File: tb/tb_irq_generator.sv
// Directed bench for irq_generator: scenario table plus hand-written timing/reset/echo sequences.
module tb_irq_generator;
    import irq_loopback_pkg::*;

    localparam int CPU_NB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    irq_generator_if #(.CPU_NB(CPU_NB)) bus_a();
    irq_generator_if #(.CPU_NB(CPU_NB)) bus_b();

    irq_generator #(.CPU_NB(CPU_NB), .TRANSACTION_NB(10), .GAP_CYCLES(2), .TIMEOUT_CYCLES(64))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    irq_generator #(.CPU_NB(CPU_NB), .TRANSACTION_NB(10), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    assign bus_b.i_irq = bus_b.o_irq;

    // Loopback model for dut_a: per-channel register delay, drop, or forced wrong echo.
    int          dly [CPU_NB];
    logic [3:0]  drop;
    logic [3:0]  force_en;
    logic [31:0] force_val;
    logic [31:0] pipe [CPU_NB][64];

    always @(posedge clk) begin
        for (int c = 0; c < CPU_NB; c++) begin
            pipe[c][0] <= bus_a.o_irq[c];
            for (int k = 1; k < 64; k++) pipe[c][k] <= pipe[c][k-1];
        end
    end

    always_comb begin
        bus_a.i_irq = '0;
        for (int c = 0; c < CPU_NB; c++) begin
            if (drop[c])           bus_a.i_irq[c] = '0;
            else if (force_en[c])  bus_a.i_irq[c] = force_val;
            else if (dly[c] == 0)  bus_a.i_irq[c] = bus_a.o_irq[c];
            else                   bus_a.i_irq[c] = pipe[c][dly[c]-1];
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endfunction

    typedef struct {
        logic [3:0][6:0]  dly;
        logic [3:0]       drop;
        logic [3:0]       exp_err;
        logic [3:0][31:0] exp_w;
    } row_t;

    row_t tbl [5];

    task automatic wait_fin_a();
        int cyc = 0;
        while (bus_a.o_finish != 4'hF && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_row(input int r);
        do_reset();
        for (int c = 0; c < CPU_NB; c++) dly[c] = int'(tbl[r].dly[c]);
        drop     = tbl[r].drop;
        force_en = '0;
        @(negedge clk);
        chk($sformatf("row%0d_rst_irq", r), bus_a.o_irq[0] | bus_a.o_irq[1] |
            bus_a.o_irq[2] | bus_a.o_irq[3], 32'h0);
        chk($sformatf("row%0d_rst_flags", r), {24'h0, bus_a.o_finish, bus_a.o_error}, 32'h0);
        rst_n = 1'b1;
        wait_fin_a();
        chk($sformatf("row%0d_finish", r), 32'(bus_a.o_finish), 32'hF);
        chk($sformatf("row%0d_error", r), 32'(bus_a.o_error), 32'(tbl[r].exp_err));
        for (int c = 0; c < CPU_NB; c++)
            chk($sformatf("row%0d_last_word_cpu%0d", r, c), bus_a.o_irq[c], tbl[r].exp_w[c]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [31:0] prev;

        rst_n     = 1'b0;
        drop      = '0;
        force_en  = '0;
        force_val = 32'hDEADBEEF;
        for (int c = 0; c < CPU_NB; c++) dly[c] = 0;

        // Wired loopback; a 64-register delay times out, 63 meets the boundary and wins.
        tbl[0].dly = {7'd0, 7'd0, 7'd0, 7'd0};   tbl[0].drop = 4'b0000; tbl[0].exp_err = 4'b0000;
        tbl[0].exp_w = {32'h0300000A, 32'h0200000A, 32'h0100000A, 32'h0000000A};
        tbl[1].dly = {7'd0, 7'd0, 7'd0, 7'd0};   tbl[1].drop = 4'b0010; tbl[1].exp_err = 4'b0010;
        tbl[1].exp_w = {32'h0300000A, 32'h0200000A, 32'h01000001, 32'h0000000A};
        tbl[2].dly = {7'd63, 7'd0, 7'd0, 7'd0};  tbl[2].drop = 4'b0000; tbl[2].exp_err = 4'b0000;
        tbl[2].exp_w = {32'h0300000A, 32'h0200000A, 32'h0100000A, 32'h0000000A};
        tbl[3].dly = {7'd0, 7'd0, 7'd0, 7'd64};  tbl[3].drop = 4'b0000; tbl[3].exp_err = 4'b0001;
        tbl[3].exp_w = {32'h0300000A, 32'h0200000A, 32'h0100000A, 32'h00000001};
        tbl[4].dly = {7'd2, 7'd10, 7'd5, 7'd1};  tbl[4].drop = 4'b0000; tbl[4].exp_err = 4'b0000;
        tbl[4].exp_w = {32'h0300000A, 32'h0200000A, 32'h0100000A, 32'h0000000A};

        // GAP_CYCLES=0 with a wired echo: a new word every 2 cycles.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (bus_b.o_irq[0] == 32'h0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("gap0_cpu0_k%0d", k), bus_b.o_irq[0], 32'(k / 2 + 1));
            chk($sformatf("gap0_cpu2_k%0d", k), bus_b.o_irq[2], 32'h02000000 | 32'(k / 2 + 1));
            @(negedge clk);
        end
        cyc = 0;
        while (bus_b.o_finish != 4'hF && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("gap0_finish", 32'(bus_b.o_finish), 32'hF);
        chk("gap0_last_cpu2", bus_b.o_irq[2], 32'h0200000A);

        for (int r = 0; r < 5; r++) run_row(r);

        // Dropped echo on cpu1: error must rise exactly 64 cycles after the issue edge.
        do_reset();
        for (int c = 0; c < CPU_NB; c++) dly[c] = 0;
        drop  = 4'b0010;
        rst_n = 1'b1;
        cyc = 0;
        while (bus_a.o_irq[1] == 32'h0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        cyc = 0;
        while (!bus_a.o_error[1] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_latency", 32'(cyc), 32'd64);
        chk("timeout_word_held", bus_a.o_irq[1], 32'h01000001);
        wait_fin_a();
        chk("timeout_others_clean", 32'(bus_a.o_error), 32'h2);

        // Reset pulsed during WAIT of word 5, then issue period 1 + 4 + 2 with 3-register echo.
        do_reset();
        drop = '0;
        for (int c = 0; c < CPU_NB; c++) dly[c] = 3;
        rst_n = 1'b1;
        cyc = 0;
        while (bus_a.o_irq[0][23:0] != 24'd5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_reached_word5", bus_a.o_irq[0], 32'h00000005);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_irq0_async", bus_a.o_irq[0], 32'h0);
        chk("midrst_irq3_async", bus_a.o_irq[3], 32'h0);
        chk("midrst_flags_async", {24'h0, bus_a.o_finish, bus_a.o_error}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (bus_a.o_irq[0] == 32'h0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_first_cpu0", bus_a.o_irq[0], 32'h00000001);
        chk("midrst_first_cpu3", bus_a.o_irq[3], 32'h03000001);
        cyc = 0;
        while (bus_a.o_irq[0] == 32'h00000001 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("issue_period", 32'(cyc), 32'd7);
        chk("second_word_cpu0", bus_a.o_irq[0], 32'h00000002);

        // Wrong echo on cpu0 is ignored; the real echo advances exactly one transaction.
        do_reset();
        for (int c = 0; c < CPU_NB; c++) dly[c] = 0;
        dly[0] = 10;
        rst_n  = 1'b1;
        cyc = 0;
        while (bus_a.o_irq[0][23:0] != 24'd3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        force_en[0] = 1'b1;
        repeat (4) @(negedge clk);
        force_en[0] = 1'b0;
        chk("bad_echo_word_held", bus_a.o_irq[0], 32'h00000003);
        prev = bus_a.o_irq[0];
        cyc = 0;
        while (bus_a.o_irq[0] == prev && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("bad_echo_next_word", bus_a.o_irq[0], 32'h00000004);
        chk("bad_echo_no_error", 32'(bus_a.o_error[0]), 32'h0);
        wait_fin_a();
        chk("bad_echo_all_clean", 32'(bus_a.o_error), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
